// File: rtl/sender_payload_mask.sv
// sender_payload_mask
// Walks every OT index once per run, reads the hashed pad pair for that
// index and XORs it onto the caller's payload pair. The masked pair leaves
// on a valid/ready stream through a 2-entry FIFO.
//
// Optional feature macro: SENDER_MASK_SWAP_EN
//   defined     - a registered x_swap=1 exchanges pad0/pad1 for that index
//                 (OT derandomization with the receiver's correction bit)
//   not defined - x_swap is accepted but never changes the result
module sender_payload_mask #(
  parameter int D       = 3,
  parameter int OT_SIZE = 8 * (2 ** D),
  parameter int AW      = $clog2(OT_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] pad_addr,
  output logic          pad_rd,
  input  logic [127:0]  pad0_data,
  input  logic [127:0]  pad1_data,
  input  logic          x_valid,
  output logic          x_ready,
  input  logic [127:0]  x0,
  input  logic [127:0]  x1,
  input  logic          x_swap,
  output logic          y_valid,
  input  logic          y_ready,
  output logic [127:0]  y0,
  output logic [127:0]  y1,
  output logic [AW-1:0] y_index
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] LAST_IDX = (AW+1)'(OT_SIZE - 1);

  state_t          state_q;
  logic [AW:0]     cnt_q;
  logic            done_q;
  logic [AW-1:0]   pad_addr_q;

  logic            s1_valid_q;
  logic [127:0]    s1_x0_q;
  logic [127:0]    s1_x1_q;
  logic            s1_swap_q;
  logic [AW-1:0]   s1_idx_q;

  logic [127:0]    fifo_y0_q  [2];
  logic [127:0]    fifo_y1_q  [2];
  logic [AW-1:0]   fifo_idx_q [2];
  logic            rd_ptr_q;
  logic            wr_ptr_q;
  logic [1:0]      count_q;
  logic [1:0]      count_d;

  logic            accept;
  logic            push;
  logic            pop;
  logic [2:0]      occupancy;
  logic [127:0]    y0_d;
  logic [127:0]    y1_d;

  // Handshake decode: a slot freed by a pop in this cycle may be reused, so
  // an accept is allowed only if its pair is certain to find room on arrival.
  always_comb begin
    pop       = (count_q != 2'd0) & y_ready;
    push      = s1_valid_q;
    occupancy = {1'b0, count_q} + {2'b00, s1_valid_q} - {2'b00, pop};
    x_ready   = (state_q == RUN) && (occupancy < 3'd2);
    accept    = x_valid & x_ready;
    pad_rd    = accept;
    pad_addr  = accept ? cnt_q[AW-1:0] : pad_addr_q;
    count_d   = count_q + {1'b0, push} - {1'b0, pop};
  end

  // Run control: start/finish sequencing, accept counter and done flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      pad_addr_q <= '0;
    end else begin
      if (accept) begin
        pad_addr_q <= cnt_q[AW-1:0];
        cnt_q      <= cnt_q + (AW+1)'(1);
      end
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            cnt_q   <= '0;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          if (accept && (cnt_q == LAST_IDX)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!s1_valid_q && (count_d == 2'd0)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stage 1 holds the accepted payload while the pad memories answer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_x0_q    <= '0;
      s1_x1_q    <= '0;
      s1_swap_q  <= 1'b0;
      s1_idx_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_x0_q   <= x0;
        s1_x1_q   <= x1;
        s1_swap_q <= x_swap;
        s1_idx_q  <= cnt_q[AW-1:0];
      end
    end
  end

`ifdef SENDER_MASK_SWAP_EN
  // Masking with optional pad exchange driven by the correction bit.
  always_comb begin
    if (s1_swap_q) begin
      y0_d = s1_x0_q ^ pad1_data;
      y1_d = s1_x1_q ^ pad0_data;
    end else begin
      y0_d = s1_x0_q ^ pad0_data;
      y1_d = s1_x1_q ^ pad1_data;
    end
  end
`else
  logic unused_swap;
  assign unused_swap = s1_swap_q;

  // Masking with the pads in their natural order.
  always_comb begin
    y0_d = s1_x0_q ^ pad0_data;
    y1_d = s1_x1_q ^ pad1_data;
  end
`endif

  // Two-entry output FIFO; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_y0_q[i]  <= '0;
        fifo_y1_q[i]  <= '0;
        fifo_idx_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_y0_q[wr_ptr_q]  <= y0_d;
        fifo_y1_q[wr_ptr_q]  <= y1_d;
        fifo_idx_q[wr_ptr_q] <= s1_idx_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign done    = done_q;
  assign y_valid = (count_q != 2'd0);
  assign y0      = fifo_y0_q[rd_ptr_q];
  assign y1      = fifo_y1_q[rd_ptr_q];
  assign y_index = fifo_idx_q[rd_ptr_q];

endmodule

// File: tb/tb_sender_payload_mask.sv
// Testbench for sender_payload_mask (D=3, 64 OTs per run).
// Pad memories hold pad0[i]=i and pad1[i]=i<<64. Expected pairs are queued
// at each accept and checked in order whenever the DUT hands a pair over.
module tb_sender_payload_mask;

  localparam int D  = 3;
  localparam int OT = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          done;
  logic [AW-1:0] pad_addr;
  logic          pad_rd;
  logic [127:0]  pad0_data = '0;
  logic [127:0]  pad1_data = '0;
  logic          x_valid;
  logic          x_ready;
  logic [127:0]  x0;
  logic [127:0]  x1;
  logic          x_swap;
  logic          y_valid;
  logic          y_ready;
  logic [127:0]  y0;
  logic [127:0]  y1;
  logic [AW-1:0] y_index;

  sender_payload_mask #(.D(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .done      (done),
    .pad_addr  (pad_addr),
    .pad_rd    (pad_rd),
    .pad0_data (pad0_data),
    .pad1_data (pad1_data),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .x0        (x0),
    .x1        (x1),
    .x_swap    (x_swap),
    .y_valid   (y_valid),
    .y_ready   (y_ready),
    .y0        (y0),
    .y1        (y1),
    .y_index   (y_index)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [127:0]  y0;
    logic [127:0]  y1;
  } exp_t;

  exp_t   expQ[$];
  int     tests = 0;
  int     fails = 0;
  int     cycleNum = 0;
  int     acceptIdx = 0;
  int     rxCount = 0;
  int     runMode = 0;
  int     startCycle = 0;
  int     firstAcceptCycle = -1;
  int     lastAcceptCycle = -1;
  int     firstYCycle = -1;
  logic   stallActive = 1'b0;
  logic   prevStall = 1'b0;
  logic [127:0]  heldY0;
  logic [127:0]  heldY1;
  logic [AW-1:0] heldIdx;

  // Pad memories answer one cycle after the read strobe.
  always @(posedge clk) begin
    if (pad_rd) begin
      pad0_data <= {122'b0, pad_addr};
      pad1_data <= {58'b0, pad_addr, 64'b0};
    end
  end

  // Free-running cycle counter for latency measurements.
  always @(posedge clk) cycleNum++;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [127:0] payload0(input int mode, input int idx);
    if (mode == 0) return 128'hFF;
    return {32'hA5A5_A5A5, 96'h0} | 128'(idx);
  endfunction

  function automatic logic [127:0] payload1(input int mode, input int idx);
    if (mode == 0) return 128'hFF;
    return {32'h5A5A_5A5A, 96'h0} | (128'(idx) << 8);
  endfunction

  // Record the expected masked pair for every accepted payload.
  always @(negedge clk) begin
    exp_t e;
    logic [127:0] pA;
    logic [127:0] pB;
    if (rst && x_valid && x_ready) begin
      pA = 128'(acceptIdx);
      pB = pA << 64;
      e.idx = 6'(acceptIdx);
`ifdef SENDER_MASK_SWAP_EN
      if (x_swap) begin
        e.y0 = x0 ^ pB;
        e.y1 = x1 ^ pA;
      end else begin
        e.y0 = x0 ^ pA;
        e.y1 = x1 ^ pB;
      end
`else
      e.y0 = x0 ^ pA;
      e.y1 = x1 ^ pB;
`endif
      expQ.push_back(e);
      if (firstAcceptCycle < 0) firstAcceptCycle = cycleNum;
      lastAcceptCycle = cycleNum;
      acceptIdx++;
    end
  end

  // Compare each handed-over pair against the queue; check head stability under stall.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prevStall = 1'b0;
    end else begin
      if (y_valid && firstYCycle < 0) firstYCycle = cycleNum;
      if (prevStall && y_valid) begin
        checkOutput("stall_y0", y0, heldY0);
        checkOutput("stall_y1", y1, heldY1);
        checkOutput("stall_idx", 128'(y_index), 128'(heldIdx));
      end
      if (y_valid && y_ready) begin
        if (expQ.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_output: got index %0d, expected no output", y_index);
        end else begin
          e = expQ.pop_front();
          checkOutput("y_index", 128'(y_index), 128'(e.idx));
          checkOutput("y0", y0, e.y0);
          checkOutput("y1", y1, e.y1);
        end
        rxCount++;
      end
      prevStall = y_valid && !y_ready;
      heldY0    = y0;
      heldY1    = y1;
      heldIdx   = y_index;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveInputs();
    x0     = payload0(runMode, acceptIdx);
    x1     = payload1(runMode, acceptIdx);
    x_swap = (runMode == 1) && (acceptIdx == 3);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_x_ready"}, 128'(x_ready), 128'(0));
    checkOutput({tag, "_y_valid"}, 128'(y_valid), 128'(0));
    checkOutput({tag, "_done"}, 128'(done), 128'(0));
    checkOutput({tag, "_pad_rd"}, 128'(pad_rd), 128'(0));
    checkOutput({tag, "_y_index"}, 128'(y_index), 128'(0));
    checkOutput({tag, "_y0"}, y0, 128'(0));
    checkOutput({tag, "_y1"}, y1, 128'(0));
  endtask

  task automatic startRun(input int mode);
    runMode          = mode;
    expQ.delete();
    acceptIdx        = 0;
    rxCount          = 0;
    firstAcceptCycle = -1;
    lastAcceptCycle  = -1;
    firstYCycle      = -1;
    driveInputs();
    start      = 1'b1;
    startCycle = cycleNum;
    tick();
    start = 1'b0;
    checkOutput("done_cleared", 128'(done), 128'(0));
  endtask

  // One complete run, optionally with a backpressure window, ignored start
  // pulses, timing checks, or a reset once a given index has been accepted.
  task automatic applyStimulus(input int mode, input bit doStall, input bit pokeStart,
                               input int resetAt, input bit checkTiming);
    int k;
    int doneCycle;
    int stallCycles;
    bit released;
    bit aborted;
    k = 0;
    doneCycle = -1;
    stallCycles = 0;
    released = 1'b0;
    aborted = 1'b0;
    stallActive = 1'b0;
    y_ready = 1'b1;
    startRun(mode);
    driveInputs();
    while (!aborted && (done !== 1'b1) && (k < 300)) begin
      start = pokeStart && (k == 10 || k == 20);
      if (checkTiming && k == 10) begin
        checkOutput("pushpop_y_valid", 128'(y_valid), 128'(1));
        checkOutput("pushpop_x_ready", 128'(x_ready), 128'(1));
      end
      if (doStall && !released) begin
        if (stallActive) begin
          stallCycles++;
          if (stallCycles == 3) begin
            checkOutput("stall_x_ready", 128'(x_ready), 128'(0));
            checkOutput("stall_pad_rd", 128'(pad_rd), 128'(0));
            checkOutput("stall_accepted", 128'(acceptIdx), 128'(7));
            checkOutput("stall_head", 128'(y_index), 128'(5));
          end
          if (stallCycles == 8) begin
            released    = 1'b1;
            stallActive = 1'b0;
          end
        end else if (y_valid && y_index == 6'd5) begin
          stallActive = 1'b1;
        end
        y_ready = !stallActive;
      end
      if (resetAt >= 0 && acceptIdx == resetAt) begin
        rst = 1'b0;
        expQ.delete();
        tick();
        tick();
        checkResetState("midreset");
        rst = 1'b1;
        expQ.delete();
        aborted = 1'b1;
      end else begin
        tick();
        driveInputs();
        k++;
      end
    end
    start = 1'b0;
    y_ready = 1'b1;
    if (!aborted) begin
      if (done !== 1'b1) begin
        tests++;
        fails++;
        $display("[TB] FAIL done_timeout: done=%b after %0d cycles, expected 1", done, k);
      end else begin
        doneCycle = cycleNum;
        checkOutput("queue_empty", 128'(expQ.size()), 128'(0));
        checkOutput("rx_count", 128'(rxCount), 128'(OT));
        if (checkTiming) begin
          checkOutput("done_latency", 128'(doneCycle - startCycle), 128'(67));
          checkOutput("first_latency", 128'(firstYCycle - firstAcceptCycle), 128'(2));
          checkOutput("throughput", 128'(lastAcceptCycle - firstAcceptCycle), 128'(63));
          tick();
          tick();
          tick();
          checkOutput("done_held", 128'(done), 128'(1));
        end
      end
    end
  endtask

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    x_valid = 1'b1;
    y_ready = 1'b1;
    x0      = '0;
    x1      = '0;
    x_swap  = 1'b0;
    tick();
    tick();
    checkResetState("reset");
    rst = 1'b1;
    tick();
    checkOutput("idle_x_ready", 128'(x_ready), 128'(0));

    applyStimulus(0, 1'b0, 1'b0, -1, 1'b1);
    applyStimulus(0, 1'b1, 1'b0, -1, 1'b0);
    applyStimulus(1, 1'b0, 1'b1, -1, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 20, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sender_payload_mask.md
# sender_payload_mask

Downstream stage of the OT sender expansion block. After that block finishes its HASH pass, this block walks every OT index, reads the pad pair (H(m0), H(m1)) from the hashed-message memories, and XORs it with the caller's payload pair (x0, x1). It emits the masked pair (y0, y1) on a valid/ready stream toward the link interface, with backpressure tolerance and a completion flag.

## Interface
- D, 3, tree depth; must match the expansion block.
- OT_SIZE, 8*(2**D), number of OTs processed per run.
- AW, $clog2(OT_SIZE), pad address width.

- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset, sampled on posedge clk.
- start  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- done  out  1  high while in DONE; reset value 0.
- pad_addr  out  AW  read address into the m0/m1 pad memories; reset value 0.
- pad_rd  out  1  read strobe; reset value 0.
- pad0_data  in  128  H(m0)[pad_addr], valid exactly 1 cycle after pad_rd.
- pad1_data  in  128  H(m1)[pad_addr], valid exactly 1 cycle after pad_rd.
- x_valid  in  1  payload pair offered.
- x_ready  out  1  payload pair accepted when x_valid & x_ready; reset value 0.
- x0, x1  in  128 each  payload pair for the current index.
- x_swap  in  1  receiver correction bit for the current index; only used with the macro.
- y_valid  out  1  masked pair available; reset value 0.
- y_ready  in  1  consumer accepts when y_valid & y_ready.
- y0, y1  out  128 each  masked pair; reset value 0.
- y_index  out  AW  OT index of the head output pair; reset value 0.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start -> RUN. Clears cnt and done.
  - RUN -> DRAIN when the accept of index OT_SIZE-1 occurs.
  - DRAIN -> DONE when the stage-1 valid bit is 0 and the output FIFO is empty.
  - start is ignored in RUN and DRAIN.
- cnt has width AW+1 and counts accepted pairs.
- Accept (x_valid & x_ready) in cycle t:
  - Drive pad_rd=1 and pad_addr=cnt[AW-1:0] combinationally in cycle t.
  - Register x0, x1, x_swap and index cnt into stage 1; cnt increments.
- Stage 1 at t+1: y0 = x0 ^ pad0_data and y1 = x1 ^ pad1_data. Push the result with its index into a 2-entry output FIFO.
- x_ready = (state==RUN) & (fifo_count + stage1_valid < 2). A pad read therefore never issues without a guaranteed FIFO slot.
- The output is the FIFO head. Pop on y_valid & y_ready. Push and pop in the same cycle are legal and leave the count unchanged.
- pad_rd is 0 whenever no accept happens. pad_addr holds its last value.
- Reset mid-run returns to IDLE and clears cnt, stage 1, FIFO and all outputs to their reset values. In-flight data is discarded.

## Timing
- Latency: accept at edge t -> y_valid high after edge t+2 when the FIFO was empty. No combinational path from x_* to y_*.
- Throughput: 1 pair/cycle sustained while y_ready=1.
- When y_ready goes low, at most 2 pairs are held. x_ready drops in the same cycle the occupancy rule fails.
- y0/y1/y_index stay stable while y_valid=1 and y_ready=0.
- done rises the cycle after the last pop and stays high until start or reset.
- Total cycles for a run with no stalls: OT_SIZE + 3 from the start pulse to done.

## Configuration
- SENDER_MASK_SWAP_EN defined: a stage-1 x_swap=1 exchanges the pads, giving y0 = x0 ^ pad1_data and y1 = x1 ^ pad0_data. This implements OT derandomization with the receiver's correction bit.
- Not defined: x_swap is ignored and the pads are never exchanged. The port remains present.

## Test plan
- Reset: hold rst=0 for 2 cycles with x_valid=1 -> x_ready=0, y_valid=0, done=0, pad_rd=0, y0=y1=0.
- Streaming: D=3 (OT_SIZE=64), pad0[i]=i, pad1[i]=i<<64, x0=x1=128'hFF, y_ready=1.
  - y0[i] = 128'hFF ^ i and y1[i] = 128'hFF ^ (i<<64), in index order 0..63.
  - First y_valid 2 cycles after the first accept; done high 67 cycles after start.
- Backpressure: hold y_ready=0 from index 5.
  - Exactly 2 pairs (indices 5, 6) are held and x_ready=0.
  - After release, no index is lost or duplicated and head data stays stable while stalled.
- Simultaneous push/pop with FIFO count 1 -> count stays 1 and x_ready stays 1.
- Swap: x_swap=1 on index 3 with the macro defined -> y0 = x0 ^ pad1[3]. Without the macro -> y0 = x0 ^ pad0[3].
- Mid-run reset at index 20, then a new start -> outputs restart at index 0 with no stale data; start pulses during RUN are ignored.
